// File: rtl/cnt_tff_ctrl.sv
// Sequencing controller for a chain of T flip-flops: turns start/stop/clear and the
// chain's current value into per-bit toggle enables, with run/pause/done sequencing.

module cnt_tff_lane (
    input  logic q,
    input  logic up_pre,
    input  logic dn_pre,
    input  logic dir,
    input  logic mode_pass,
    input  logic mode_inv,
    input  logic mode_cnt,
    output logic t_en
);
    // Toggling with T=Q drives the bit to 0, T=~Q drives it to 1.
    assign t_en = (mode_pass & q) | (mode_inv & ~q) | (mode_cnt & (dir ? dn_pre : up_pre));
endmodule

module cnt_tff_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic             CLR,
    input  logic             ONESHOT,
    input  logic             DIR,
    input  logic [WIDTH-1:0] TC_VAL,
    input  logic [WIDTH-1:0] Q_IN,
    output logic [WIDTH-1:0] T_EN,
    output logic             BUSY,
    output logic             DONE,
    output logic             WRAP,
    output logic [1:0]       STATE
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic             oneshot_q, oneshot_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] tc_q, tc_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;

    logic             mode_pass, mode_inv, mode_cnt;
    logic [WIDTH-1:0] up_pre, dn_pre;

    // Carry/borrow prefixes: bit i toggles when all lower bits are 1 (up) or 0 (down).
    assign up_pre[0] = 1'b1;
    assign dn_pre[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_pre
        assign up_pre[i] = up_pre[i-1] & Q_IN[i-1];
        assign dn_pre[i] = dn_pre[i-1] & ~Q_IN[i-1];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        cnt_tff_lane u_lane (
            .q         (Q_IN[i]),
            .up_pre    (up_pre[i]),
            .dn_pre    (dn_pre[i]),
            .dir       (dir_q),
            .mode_pass (mode_pass),
            .mode_inv  (mode_inv),
            .mode_cnt  (mode_cnt),
            .t_en      (T_EN[i])
        );
    end

    always_comb begin
        state_d   = state_q;
        oneshot_d = oneshot_q;
        dir_d     = dir_q;
        tc_d      = tc_q;
        done_d    = 1'b0;
        wrap_d    = 1'b0;
        mode_pass = 1'b0;
        mode_inv  = 1'b0;
        mode_cnt  = 1'b0;
        if (CLR) begin
            mode_pass = 1'b1;
            state_d   = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START && !STOP) begin
                        oneshot_d = ONESHOT;
                        dir_d     = DIR;
                        tc_d      = TC_VAL;
                        state_d   = S_RUN;
                    end
                end
                S_RUN: begin
                    if (STOP) begin
                        state_d = S_PAUSE;
                    end else if (Q_IN == tc_q) begin
                        if (oneshot_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            mode_pass = ~dir_q;
                            mode_inv  = dir_q;
                            wrap_d    = 1'b1;
                        end
                    end else begin
                        mode_cnt = 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (START && !STOP) state_d = S_RUN;
                end
                S_DONE: begin
                    // Relaunch also clears the held terminal count on the same edge.
                    if (START && !STOP) begin
                        oneshot_d = ONESHOT;
                        dir_d     = DIR;
                        tc_d      = TC_VAL;
                        state_d   = S_RUN;
                        mode_pass = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            oneshot_q <= 1'b0;
            dir_q     <= 1'b0;
            tc_q      <= '0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            oneshot_q <= oneshot_d;
            dir_q     <= dir_d;
            tc_q      <= tc_d;
            done_q    <= done_d;
            wrap_q    <= wrap_d;
        end
    end

    assign BUSY  = (state_q == S_RUN);
    assign DONE  = done_q;
    assign WRAP  = wrap_q;
    assign STATE = state_q;
endmodule
